// File: rtl/skip_cnt_param.sv
// Parametrised up/down counter that never emits nonzero multiples of SKIP_N.
// Optional SKIP_CNT_BYPASS_EN adds skip_dis to count through every value.
module skip_cnt_param #(
  parameter int WIDTH  = 8,
  parameter int SKIP_N = 3,
  parameter int LIMIT  = 254
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      dir,
  input  logic                      clr,
`ifdef SKIP_CNT_BYPASS_EN
  input  logic                      skip_dis,
`endif
  output logic [WIDTH-1:0]          count,
  output logic [$clog2(SKIP_N)-1:0] phase,
  output logic                      wrap
);

  localparam int PW  = $clog2(SKIP_N);
  localparam int TOP = (LIMIT % SKIP_N == 0) ? LIMIT - 1 : LIMIT;

  localparam logic [WIDTH-1:0] TOP_V  = WIDTH'(TOP);
  localparam logic [WIDTH-1:0] LIM_V  = WIDTH'(LIMIT);
  localparam logic [WIDTH:0]   LIM_W  = (WIDTH+1)'(LIMIT);
  localparam logic [PW-1:0]    TOP_PH = PW'(TOP % SKIP_N);
  localparam logic [PW-1:0]    LIM_PH = PW'(LIMIT % SKIP_N);
  localparam logic [PW-1:0]    PH_MAX = PW'(SKIP_N - 1);
  localparam logic [PW-1:0]    PH_ONE = PW'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic             skip;
  logic             step2;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    ph_inc;
  logic [PW-1:0]    ph_dec;

`ifdef SKIP_CNT_BYPASS_EN
  assign skip = ~skip_dis;
`else
  assign skip = 1'b1;
`endif

  assign step2  = skip && (phase_q == PH_MAX);
  assign sum    = {1'b0, count_q} + (step2 ? (WIDTH+1)'(2)
                                           : (WIDTH+1)'(1));
  assign ph_inc = (phase_q == PH_MAX) ? '0 : phase_q + PH_ONE;
  assign ph_dec = (phase_q == '0) ? PH_MAX : phase_q - PH_ONE;

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = '0;
      phase_d = '0;
    end else if (en) begin
      if (dir) begin
        // Compare one bit wider so LIMIT = 2^WIDTH-1 cannot overflow.
        if (sum > LIM_W) begin
          count_d = '0;
          phase_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = sum[WIDTH-1:0];
          phase_d = step2 ? PH_ONE : ph_inc;
        end
      end else if (count_q == '0) begin
        count_d = skip ? TOP_V : LIM_V;
        phase_d = skip ? TOP_PH : LIM_PH;
        wrap_d  = 1'b1;
      end else if (count_q == WIDTH'(1)) begin
        count_d = '0;
        phase_d = '0;
      end else if (skip && phase_q == PH_ONE) begin
        count_d = count_q - WIDTH'(2);
        phase_d = PH_MAX;
      end else begin
        count_d = count_q - WIDTH'(1);
        phase_d = ph_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      phase_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign phase = phase_q;
  assign wrap  = wrap_q;

endmodule
